// File: rtl/alu_operand_if.sv
// alu_operand_if: groups the decode-side offer, the forwarding buses and the
// ALU-side outputs of alu_operand_stage. The master modport is the
// surrounding pipeline. The slave modport is the operand stage.
// Data buses are [0:XLEN-1] with bit 0 as the MSB.
interface alu_operand_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
);
  // decode side
  logic            in_valid;
  logic            in_ready;
  logic [0:XLEN-1] rs1_val;
  logic [0:XLEN-1] rs2_val;
  logic [RIDX-1:0] rs1_idx;
  logic [RIDX-1:0] rs2_idx;
  logic [RIDX-1:0] rd_idx;
  logic [0:15]     imm;
  logic            use_imm;
  logic            imm_sext;
  logic [0:3]      ctrl_in;
  logic            flush;
  // forwarding sources
  logic            exm_wen;
  logic [RIDX-1:0] exm_rd;
  logic [0:XLEN-1] exm_result;
  logic            mwb_wen;
  logic [RIDX-1:0] mwb_rd;
  logic [0:XLEN-1] mwb_result;
  // ALU side
  logic            out_valid;
  logic            out_ready;
  logic [0:XLEN-1] alu_a;
  logic [0:XLEN-1] alu_b;
  logic [0:3]      alu_ctrl;
  logic [RIDX-1:0] out_rd;

  modport master (
    output in_valid, rs1_val, rs2_val, rs1_idx, rs2_idx, rd_idx,
           imm, use_imm, imm_sext, ctrl_in, flush,
           exm_wen, exm_rd, exm_result, mwb_wen, mwb_rd, mwb_result,
           out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_rd
  );

  modport slave (
    input  in_valid, rs1_val, rs2_val, rs1_idx, rs2_idx, rd_idx,
           imm, use_imm, imm_sext, ctrl_in, flush,
           exm_wen, exm_rd, exm_result, mwb_wen, mwb_rd, mwb_result,
           out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_rd
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode -> ALU pipeline register with immediate select,
// EX/MEM and MEM/WB operand forwarding, and a valid/ready handshake with
// stall and flush.
// Build option: define ALU_OPERAND_FWD_EN to compile in the forwarding muxes
// and the hold refresh. When it is undefined, the ALU operands are the stored
// values, the exm_*/mwb_* inputs are ignored, and decode must stall on hazards.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_operand_if.slave  bus
);

  logic            r_valid;
  logic [0:XLEN-1] r_a;
  logic [0:XLEN-1] r_b;
  logic [RIDX-1:0] r_rs1_idx;
  logic [RIDX-1:0] r_rs2_idx;
  logic [RIDX-1:0] r_rd;
  logic [0:3]      r_ctrl;

  logic            w_in_ready;
  logic            w_capture;
  logic [0:XLEN-1] w_imm_ext;
  logic [0:XLEN-1] w_b_src;
  logic [0:XLEN-1] w_fwd_a;
  logic [0:XLEN-1] w_fwd_b;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

  // Immediate extension and B-source select. imm[0] is the immediate's MSB.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can leave it unassigned and infer a latch.
    w_imm_ext = {{(XLEN-16){bus.imm_sext & bus.imm[0]}}, bus.imm};
    w_b_src   = bus.use_imm ? w_imm_ext : bus.rs2_val;
  end

`ifdef ALU_OPERAND_FWD_EN
  // Per-operand forwarding. EX/MEM is newer than MEM/WB, so it wins. Index 0 is never forwarded.
  always_comb begin
    w_fwd_a = r_a;
    w_fwd_b = r_b;
    if (bus.exm_wen && (bus.exm_rd == r_rs1_idx) && (r_rs1_idx != '0))
      w_fwd_a = bus.exm_result;
    else if (bus.mwb_wen && (bus.mwb_rd == r_rs1_idx) && (r_rs1_idx != '0))
      w_fwd_a = bus.mwb_result;
    if (bus.exm_wen && (bus.exm_rd == r_rs2_idx) && (r_rs2_idx != '0))
      w_fwd_b = bus.exm_result;
    else if (bus.mwb_wen && (bus.mwb_rd == r_rs2_idx) && (r_rs2_idx != '0))
      w_fwd_b = bus.mwb_result;
  end
`else
  // Without forwarding the ALU sees the stored operands unchanged.
  always_comb begin
    w_fwd_a = r_a;
    w_fwd_b = r_b;
  end
`endif

  // Pipeline register: flush beats capture. Otherwise retire on acceptance, or refresh operands while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operands are reset along with the control bits, because alu_a/alu_b are visible outputs while out_valid=0.
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_rs1_idx <= '0;
      r_rs2_idx <= '0;
      r_rd      <= '0;
      r_ctrl    <= 4'b0000;
    end else if (bus.flush) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_a       <= bus.rs1_val;
      r_b       <= w_b_src;
      r_rs1_idx <= bus.rs1_idx;
      // An immediate B must never match a forwarding destination.
      r_rs2_idx <= bus.use_imm ? '0 : bus.rs2_idx;
      r_rd      <= bus.rd_idx;
      r_ctrl    <= bus.ctrl_in;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
`ifdef ALU_OPERAND_FWD_EN
    else if (r_valid) begin
      // Stalled: latch the forwarded value before its producer leaves the bus.
      r_a <= w_fwd_a;
      r_b <= w_fwd_b;
    end
`endif
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.alu_a     = w_fwd_a;
  assign bus.alu_b     = w_fwd_b;
  assign bus.alu_ctrl  = r_ctrl;
  assign bus.out_rd    = r_rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes the expected ALU
// operands, and a monitor pops and compares them on every accepted output.
// Expectations follow ALU_OPERAND_FWD_EN when it is defined for the build.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];

  alu_operand_if #(.XLEN(32), .RIDX(5)) bus ();

  alu_operand_stage #(.XLEN(32), .RIDX(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: compares each accepted ALU transfer against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_alu_a", bus.alu_a, e.a);
        check("out_alu_b", bus.alu_b, e.b);
        check("out_alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, e.ctrl});
        check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
      end
    end
  end

  task automatic set_vec(input logic [31:0] v1, input logic [31:0] v2,
                         input logic [4:0] i1, input logic [4:0] i2, input logic [4:0] rd,
                         input logic [3:0] ctrl, input logic ui, input logic [15:0] im,
                         input logic sx);
    bus.rs1_val  = v1;
    bus.rs2_val  = v2;
    bus.rs1_idx  = i1;
    bus.rs2_idx  = i2;
    bus.rd_idx   = rd;
    bus.ctrl_in  = ctrl;
    bus.use_imm  = ui;
    bus.imm      = im;
    bus.imm_sext = sx;
  endtask

  // Offer one instruction for a single edge, then withdraw it.
  task automatic issue_one();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic fwd_off();
    bus.exm_wen = 1'b0; bus.exm_rd = '0; bus.exm_result = '0;
    bus.mwb_wen = 1'b0; bus.mwb_rd = '0; bus.mwb_result = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_vec(32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 16'd0, 1'b0);
    fwd_off();

    // Reset state
    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Basic capture: sub 5,3 -> rd 3
    bus.out_ready = 1'b1;
    set_vec(32'd5, 32'd3, 5'd1, 5'd2, 5'd3, 4'b0001, 1'b0, 16'd0, 1'b0);
    exp_q.push_back('{a: 32'd5, b: 32'd3, ctrl: 4'b0001, rd: 5'd3});
    issue_one();
    check("basic_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    check("basic_retire", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back immediates. mwb targets the original rs2 index, which must not forward.
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd2; bus.mwb_result = 32'h99;
    set_vec(32'd7, 32'h1234, 5'd1, 5'd2, 5'd4, 4'b0000, 1'b1, 16'hFFFE, 1'b1);
    exp_q.push_back('{a: 32'd7, b: 32'hFFFFFFFE, ctrl: 4'b0000, rd: 5'd4});
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_vec(32'd8, 32'h1234, 5'd1, 5'd2, 5'd5, 4'b1110, 1'b1, 16'hFFFE, 1'b0);
    exp_q.push_back('{a: 32'd8, b: 32'h0000FFFE, ctrl: 4'b1110, rd: 5'd5});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    fwd_off();

    // EX/MEM has priority over MEM/WB
    bus.exm_wen = 1'b1; bus.exm_rd = 5'd4; bus.exm_result = 32'hAA;
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_result = 32'hBB;
    set_vec(32'h11, 32'h22, 5'd4, 5'd0, 5'd6, 4'b0010, 1'b0, 16'd0, 1'b0);
    exp_q.push_back('{a: FWD ? 32'hAA : 32'h11, b: 32'h22, ctrl: 4'b0010, rd: 5'd6});
    issue_one();
    @(posedge clk); #1;

    // MEM/WB alone forwards
    bus.exm_wen = 1'b0;
    set_vec(32'h11, 32'h22, 5'd4, 5'd0, 5'd6, 4'b1111, 1'b0, 16'd0, 1'b0);
    exp_q.push_back('{a: FWD ? 32'hBB : 32'h11, b: 32'h22, ctrl: 4'b1111, rd: 5'd6});
    issue_one();
    @(posedge clk); #1;

    // Index 0 never forwards
    bus.exm_wen = 1'b1; bus.exm_rd = 5'd0;
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd0;
    set_vec(32'h31, 32'h32, 5'd0, 5'd0, 5'd1, 4'b1011, 1'b0, 16'd0, 1'b0);
    exp_q.push_back('{a: 32'h31, b: 32'h32, ctrl: 4'b1011, rd: 5'd1});
    issue_one();
    @(posedge clk); #1;
    fwd_off();

    // Three-cycle stall, with mwb matching rs2 only in cycle 1
    bus.out_ready = 1'b0;
    set_vec(32'h1, 32'h10, 5'd1, 5'd6, 5'd7, 4'b0111, 1'b0, 16'd0, 1'b0);
    issue_one();
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd6; bus.mwb_result = 32'h77;
    #1;
    check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("hold_c1_alu_b", bus.alu_b, FWD ? 32'h77 : 32'h10);
    @(posedge clk); #1;
    fwd_off();
    #1;
    check("hold_c2_alu_b", bus.alu_b, FWD ? 32'h77 : 32'h10);
    @(posedge clk); #2;
    check("hold_c3_alu_b", bus.alu_b, FWD ? 32'h77 : 32'h10);
    exp_q.push_back('{a: 32'h1, b: FWD ? 32'h77 : 32'h10, ctrl: 4'b0111, rd: 5'd7});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_retire", {31'd0, bus.out_valid}, 32'd0);

    // Flush while holding, with a new instruction offered
    bus.out_ready = 1'b0;
    set_vec(32'h40, 32'h41, 5'd1, 5'd2, 5'd8, 4'b0100, 1'b0, 16'd0, 1'b0);
    issue_one();
    set_vec(32'h50, 32'h51, 5'd1, 5'd2, 5'd9, 4'b0101, 1'b0, 16'd0, 1'b0);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_hold_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Flush with an empty stage: the incoming instruction is dropped
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_empty_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset during a stall
    bus.out_ready = 1'b0;
    set_vec(32'h60, 32'h61, 5'd0, 5'd0, 5'd9, 4'b1010, 1'b0, 16'd0, 1'b0);
    issue_one();
    check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("pre_rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'hA);
    check("pre_rst_out_rd", {27'd0, bus.out_rd}, 32'd9);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("async_rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("async_rst_alu_a", bus.alu_a, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline register between decode and the 32-bit ALU. It captures decoded operands, the 4-bit ALU opcode and the destination index, and selects an immediate or register for operand B. It resolves read-after-write hazards by forwarding from the EX/MEM and MEM/WB result buses. Its outputs drive the ALU `A`, `B` and `ctrl` inputs directly, under a valid/ready handshake with stall and flush.

## Interface
- `XLEN`, 32: datapath width; all data buses are declared `[0:XLEN-1]`, with bit 0 as the MSB.
- `RIDX`, 5: register index width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode offers an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `rs1_val`, `rs2_val`  in  XLEN  register-file read data.
- `rs1_idx`, `rs2_idx`, `rd_idx`  in  RIDX  source and destination indices.
- `imm`  in  16 (`[0:15]`)  immediate field.
- `use_imm`  in  1  when 1, B comes from the extended immediate.
- `imm_sext`  in  1  when 1, sign-extend `imm[0]`; when 0, zero-extend.
- `ctrl_in`  in  4 (`[0:3]`)  ALU opcode.
- `flush`  in  1  discard held and incoming instruction.
- `exm_wen`, `exm_rd`, `exm_result`  in  1/RIDX/XLEN  EX/MEM forwarding source.
- `mwb_wen`, `mwb_rd`, `mwb_result`  in  1/RIDX/XLEN  MEM/WB forwarding source.
- `out_valid`  out  1  ALU inputs are valid.
- `out_ready`  in  1  downstream (EX/MEM) accepts.
- `alu_a`, `alu_b`  out  XLEN  ALU operands, after forwarding.
- `alu_ctrl`  out  4  registered opcode.
- `out_rd`  out  RIDX  registered destination index.

## Operation
- `in_ready = !out_valid || out_ready`.
- Capture occurs when `in_valid && in_ready && !flush`. On capture, the stage stores `rs1_val`, the B source, both source indices, `rd_idx` and `ctrl_in`, and sets `out_valid`.
- B source: `use_imm=1` selects the extended immediate. In that case the stored `rs2_idx` is forced to 0 so operand B is never forwarded.
- If `out_valid && out_ready && !capture`, the stage clears `out_valid`.
- Forwarding is combinational on the stored operands, per operand:
  - If `exm_wen` and `exm_rd == idx` and `idx != 0`, use `exm_result`.
  - Otherwise, if `mwb_wen` and `mwb_rd == idx` and `idx != 0`, use `mwb_result`.
  - Otherwise use the stored value.
  - EX/MEM has priority over MEM/WB.
- Hold refresh: while `out_valid && !out_ready`, each edge writes the forwarded `alu_a`/`alu_b` back into the stored operands. This keeps a value that retires from the forwarding buses during a stall.
- Flush: on the edge where `flush=1`, clear `out_valid` and drop any incoming instruction. Flush dominates capture.
- Opcode passthrough: `0000` add, `0001` sub, `0010` slt, `0011` sle, `0100` sgt, `0101` sge, `0111` sra, `1001` sll, `1010` srl, `1011` seq, `1100` sne, `1110` or, `1111` xor, remaining codes and. The stage does not interpret opcodes.
- Shift amount is `alu_b[27:31]` and is the ALU's responsibility; the stage passes B unmodified.

## Timing
- Reset (asynchronous, `rst_n=0`): `out_valid=0`, stored operands 0, `alu_ctrl=4'b0000`, `out_rd=0`, stored indices 0.
  - `in_ready` reads 1 during and after reset.
  - `alu_a`/`alu_b` read 0 unless a forwarding source matches a nonzero index; with indices at 0 this never happens.
- Latency: 1 cycle from capture edge to `out_valid=1`.
- Throughput: 1 per cycle when `out_ready=1`.
- Back-to-back capture: when `out_valid && out_ready && in_valid`, the new instruction replaces the old on the same edge and `out_valid` stays 1.
- Reset asserted mid-stall: contents are lost and `out_valid` drops immediately (asynchronous).
- Forwarding mux output settles in the same cycle as changes on `exm_*`/`mwb_*`. There is no added latency.

## Configuration
- `ALU_OPERAND_FWD_EN` defined: forwarding muxes and hold refresh are compiled in, as described above.
- `ALU_OPERAND_FWD_EN` undefined:
  - `alu_a`/`alu_b` are the stored values.
  - `exm_*`/`mwb_*` are ignored.
  - There is no hold refresh.
  - Decode must stall on hazards.
  - Ports remain present.

## Test plan
- Reset, then `rs1_val=5`, `rs2_val=3`, `ctrl_in=0001`, indices 1/2/3 -> the next cycle shows `out_valid=1`, `alu_a=5`, `alu_b=3`, `alu_ctrl=0001`, `out_rd=3`.
- `use_imm=1`, `imm=16'hFFFE`, `imm_sext=1` -> `alu_b=32'hFFFFFFFE`. With `imm_sext=0` -> `alu_b=32'h0000FFFE`. With `mwb_rd` equal to the original `rs2_idx`, no forwarding occurs.
- Stored `rs1_idx=4` with `exm_wen=1`, `exm_rd=4`, `exm_result=32'hAA`, and `mwb_wen=1`, `mwb_rd=4`, `mwb_result=32'hBB` -> `alu_a=32'hAA`. A matching index of 0 -> the stored value is used.
- Hold `out_ready=0` for 3 cycles, with `mwb` matching `rs2` in cycle 1 only (`32'h77`) -> `alu_b` stays `32'h77` through cycle 3 and is accepted when `out_ready=1`.
- `flush=1` together with `in_valid=1` while holding -> the next cycle has `out_valid=0` and the incoming instruction is not captured.
- Drop `rst_n` during a stall -> `out_valid`, `alu_ctrl` and `out_rd` go to 0 without a clock edge.
